// File: rtl/lcd_write_arbiter.sv
// lcd_write_arbiter: round-robin arbiter that shares one SPI word writer
// between several LCD content generators. A granted channel keeps the writer
// for its whole burst (until it flags ch_last), every word is acknowledged
// back to its source, and a watchdog drops words the writer never finishes.
// Channel 0 is the panel-init channel and is the only one served while
// init_done is low.
module lcd_write_arbiter #(
  parameter int NUM_CH  = 3,
  parameter int DATA_W  = 9,
  parameter int TIMEOUT = 4096,
  parameter int CNT_W   = 13
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic                     init_done,
  input  logic [NUM_CH-1:0]        ch_valid,
  input  logic [NUM_CH-1:0]        ch_last,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic [NUM_CH-1:0]        ch_ack,
  output logic [DATA_W-1:0]        data,
  output logic                     en_write,
  input  logic                     wr_done,
  output logic                     busy,
  output logic [2:0]               grant_id,
  output logic                     timeout_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_ACK   = 2'd3;

  logic [1:0]        state;
  logic [2:0]        rr_ptr;
  logic [CNT_W-1:0]  watchdog;
  logic              burst_end;

  logic [7:0]        elig;
  logic              pick_found;
  logic [2:0]        pick_idx;
  logic [3:0]        cand;

  logic [DATA_W-1:0] sel_data;
  logic              sel_last;
  logic              sel_valid;
  logic [NUM_CH-1:0] ack_onehot;
  logic [2:0]        next_ptr;
  logic              wd_expired;
  logic              release_grant;

  // Without init_done only the init channel may compete; otherwise anyone asking.
  assign elig = init_done ? 8'(ch_valid) : {7'd0, ch_valid[0]};

  // Round-robin search: first eligible channel at or after rr_ptr, wrapping at NUM_CH.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = 3'd0;
    cand       = 4'd0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand = {1'b0, rr_ptr} + 4'(k);
      if (cand >= 4'(NUM_CH)) begin
        cand = cand - 4'(NUM_CH);
      end
      if (!pick_found && elig[cand[2:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[2:0];
      end
    end
  end

  // Route the granted channel's word, flags and ack line.
  always_comb begin
    sel_data   = '0;
    sel_last   = 1'b0;
    sel_valid  = 1'b0;
    ack_onehot = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant_id == 3'(i)) begin
        sel_data      = ch_data[i*DATA_W +: DATA_W];
        sel_last      = ch_last[i];
        sel_valid     = ch_valid[i];
        ack_onehot[i] = 1'b1;
      end
    end
  end

  assign next_ptr      = (grant_id == 3'(NUM_CH - 1)) ? 3'd0 : grant_id + 3'd1;
  assign wd_expired    = (watchdog == CNT_W'(TIMEOUT - 1));
  // A re-init request ends any non-init burst at the next word boundary.
  assign release_grant = burst_end || (!init_done && grant_id != 3'd0);

  // Main arbitration FSM: grant, issue one word, wait for completion, ack, repeat.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state       <= S_IDLE;
      ch_ack      <= '0;
      data        <= '0;
      en_write    <= 1'b0;
      busy        <= 1'b0;
      grant_id    <= 3'd0;
      timeout_err <= 1'b0;
      rr_ptr      <= 3'd0;
      watchdog    <= '0;
      burst_end   <= 1'b0;
    end else begin
      en_write <= 1'b0;
      ch_ack   <= '0;
      case (state)
        S_IDLE: begin
          if (pick_found) begin
            grant_id <= pick_idx;
            busy     <= 1'b1;
            state    <= S_ISSUE;
          end else begin
            busy <= 1'b0;
          end
        end
        S_ISSUE: begin
          data     <= sel_data;
          en_write <= 1'b1;
          watchdog <= '0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          watchdog <= watchdog + 1'b1;
          if (wr_done) begin
            ch_ack    <= ack_onehot;
            burst_end <= sel_last;
            state     <= S_ACK;
          end else if (wd_expired) begin
            timeout_err <= 1'b1;
            ch_ack      <= ack_onehot;
            burst_end   <= 1'b1;
            state       <= S_ACK;
          end
        end
        S_ACK: begin
          if (release_grant) begin
            rr_ptr    <= next_ptr;
            busy      <= 1'b0;
            burst_end <= 1'b0;
            state     <= S_IDLE;
          end else if (sel_valid) begin
            state <= S_ISSUE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_write_arbiter.sv
// tb_lcd_write_arbiter: directed bench for lcd_write_arbiter with a short
// watchdog (TIMEOUT=32). All driving and sampling happens 1 time unit after
// the rising edge. Latencies below count rising edges from the sample point
// until en_write is seen high: 2 for a fresh grant out of IDLE, 1 for the
// next word of a continuing burst (2 edges after the wr_done edge).
module tb_lcd_write_arbiter;

  localparam int NUM_CH  = 3;
  localparam int DATA_W  = 9;
  localparam int TIMEOUT = 32;
  localparam int CNT_W   = 6;

  logic                     sys_clk;
  logic                     sys_rst;
  logic                     init_done;
  logic [NUM_CH-1:0]        ch_valid;
  logic [NUM_CH-1:0]        ch_last;
  logic [NUM_CH*DATA_W-1:0] ch_data;
  logic [NUM_CH-1:0]        ch_ack;
  logic [DATA_W-1:0]        data;
  logic                     en_write;
  logic                     wr_done;
  logic                     busy;
  logic [2:0]               grant_id;
  logic                     timeout_err;

  int tests;
  int failures;

  lcd_write_arbiter #(
    .NUM_CH (NUM_CH),
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT),
    .CNT_W  (CNT_W)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .init_done  (init_done),
    .ch_valid   (ch_valid),
    .ch_last    (ch_last),
    .ch_data    (ch_data),
    .ch_ack     (ch_ack),
    .data       (data),
    .en_write   (en_write),
    .wr_done    (wr_done),
    .busy       (busy),
    .grant_id   (grant_id),
    .timeout_err(timeout_err)
  );

  // Free-running 10-unit clock.
  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_data(input int ch, input logic [DATA_W-1:0] d);
    ch_data[ch*DATA_W +: DATA_W] = d;
  endtask

  task automatic wait_en(input int bound, output int n);
    n = 0;
    while (en_write !== 1'b1 && n < bound) begin
      tick();
      n++;
    end
  endtask

  // One complete word: wait for en_write, check grant/data, return wr_done
  // wdelay edges after en_write, check the single-cycle ack.
  task automatic do_word(input string tag, input logic [2:0] g, input logic [DATA_W-1:0] d,
                         input int lat, input int wdelay);
    int n;
    logic [NUM_CH-1:0] oh;
    oh = 3'b001 << g;
    wait_en(20, n);
    check({tag, "_lat"}, n, lat);
    check({tag, "_grant"}, grant_id, g);
    check({tag, "_data"}, data, d);
    check({tag, "_busy"}, busy, 1);
    repeat (wdelay - 1) tick();
    wr_done = 1'b1;
    tick();
    wr_done = 1'b0;
    check({tag, "_ack"}, ch_ack, oh);
    tick();
    check({tag, "_ack_clr"}, ch_ack, 0);
  endtask

  initial begin
    int n;
    logic seen;
    tests     = 0;
    failures  = 0;
    sys_rst   = 1'b1;
    init_done = 1'b0;
    ch_valid  = '0;
    ch_last   = '0;
    ch_data   = '0;
    wr_done   = 1'b0;
    tick();
    tick();
    check("rst_ack", ch_ack, 0);
    check("rst_data", data, 0);
    check("rst_en", en_write, 0);
    check("rst_busy", busy, 0);
    check("rst_grant", grant_id, 0);
    check("rst_terr", timeout_err, 0);
    sys_rst = 1'b0;

    // Init-only mode: channels 1 and 2 asking must be ignored.
    set_data(1, 9'h0A1);
    set_data(2, 9'h0B2);
    ch_valid = 3'b110;
    seen = 1'b0;
    repeat (4) begin
      tick();
      seen = seen | en_write | busy;
    end
    check("initonly_idle", seen, 0);
    set_data(0, 9'h111);
    ch_last  = 3'b001;
    ch_valid = 3'b111;
    do_word("init_w", 3'd0, 9'h111, 2, 2);
    ch_valid = 3'b000;

    // Fresh reset, then full round robin with single-word bursts.
    sys_rst = 1'b1;
    tick();
    sys_rst   = 1'b0;
    init_done = 1'b1;
    set_data(0, 9'h100);
    set_data(1, 9'h0A1);
    set_data(2, 9'h1B2);
    ch_last  = 3'b111;
    ch_valid = 3'b111;
    do_word("rr0", 3'd0, 9'h100, 2, 5);
    do_word("rr1", 3'd1, 9'h0A1, 2, 5);
    do_word("rr2", 3'd2, 9'h1B2, 2, 5);
    do_word("rr3", 3'd0, 9'h100, 2, 5);
    ch_valid = 3'b000;

    // Channel 1 locks a 4-word burst while channel 2 waits.
    set_data(1, 9'h0C0);
    set_data(2, 9'h0D0);
    ch_last  = 3'b000;
    ch_valid = 3'b110;
    do_word("b0", 3'd1, 9'h0C0, 2, 3);
    set_data(1, 9'h0C1);
    do_word("b1", 3'd1, 9'h0C1, 1, 3);
    set_data(1, 9'h0C2);
    do_word("b2", 3'd1, 9'h0C2, 1, 3);
    set_data(1, 9'h0C3);
    ch_last = 3'b010;
    do_word("b3", 3'd1, 9'h0C3, 1, 3);
    ch_valid = 3'b100;
    ch_last  = 3'b100;
    do_word("b_ch2", 3'd2, 9'h0D0, 2, 3);
    ch_valid = 3'b000;

    // Watchdog: wr_done withheld, word dropped at edge 32 after en_write.
    set_data(0, 9'h1EE);
    set_data(1, 9'h0C9);
    ch_last  = 3'b000;
    ch_valid = 3'b011;
    wait_en(20, n);
    check("to_lat", n, 2);
    check("to_grant", grant_id, 0);
    seen = 1'b0;
    repeat (31) begin
      tick();
      seen = seen | (|ch_ack);
    end
    check("to_noack_early", seen, 0);
    check("to_terr_early", timeout_err, 0);
    tick();
    check("to_ack", ch_ack, 3'b001);
    check("to_terr", timeout_err, 1);
    ch_valid = 3'b010;
    ch_last  = 3'b010;
    tick();
    check("to_ack_clr", ch_ack, 0);
    check("to_release", busy, 0);
    do_word("to_next", 3'd1, 9'h0C9, 2, 3);
    check("to_terr_sticky", timeout_err, 1);
    ch_valid = 3'b000;

    // wr_done on the expiry edge counts as success.
    sys_rst = 1'b1;
    tick();
    check("rst2_terr", timeout_err, 0);
    check("rst2_busy", busy, 0);
    sys_rst = 1'b0;
    set_data(0, 9'h055);
    ch_last  = 3'b001;
    ch_valid = 3'b001;
    wait_en(20, n);
    check("edge_lat", n, 2);
    repeat (31) tick();
    wr_done = 1'b1;
    tick();
    wr_done = 1'b0;
    check("edge_ack", ch_ack, 3'b001);
    check("edge_terr", timeout_err, 0);
    ch_valid = 3'b000;
    tick();
    check("edge_terr_after", timeout_err, 0);

    // init_done falls during a channel-2 burst.
    set_data(0, 9'h1F0);
    set_data(2, 9'h1A0);
    ch_last  = 3'b001;
    ch_valid = 3'b101;
    do_word("ri0", 3'd2, 9'h1A0, 2, 3);
    set_data(2, 9'h1A1);
    wait_en(20, n);
    check("ri1_lat", n, 1);
    check("ri1_grant", grant_id, 2);
    check("ri1_data", data, 9'h1A1);
    init_done = 1'b0;
    tick();
    tick();
    wr_done = 1'b1;
    tick();
    wr_done = 1'b0;
    check("ri1_ack", ch_ack, 3'b100);
    tick();
    check("ri1_release", busy, 0);
    do_word("ri_ch0", 3'd0, 9'h1F0, 2, 3);
    ch_valid = 3'b100;
    seen = 1'b0;
    repeat (4) begin
      tick();
      seen = seen | en_write | busy;
    end
    check("ri_ch2_blocked", seen, 0);

    // Reset in the middle of a word: no ack, everything back to zero.
    init_done = 1'b1;
    wait_en(20, n);
    check("rw_lat", n, 2);
    check("rw_grant", grant_id, 2);
    tick();
    tick();
    sys_rst = 1'b1;
    tick();
    check("rw_busy", busy, 0);
    check("rw_en", en_write, 0);
    check("rw_grant0", grant_id, 0);
    check("rw_data", data, 0);
    check("rw_ack", ch_ack, 0);
    sys_rst  = 1'b0;
    ch_valid = 3'b000;
    wr_done  = 1'b1;
    tick();
    wr_done = 1'b0;
    check("rw_late_done", ch_ack, 0);
    tick();
    check("rw_no_ack", ch_ack, 0);
    check("rw_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
